// File: rtl/control_seq_pkg.sv
// control_seq_pkg: opcode constants, T-state encodings and strobe bit indices
// shared by the control sequencer and its instruction register.
package control_seq_pkg;

    // Opcodes 0111..1101 are undefined and decode to no strobes.
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam int NSTB       = 14;
    localparam int S_PC_OUT   = 0;
    localparam int S_PC_INC   = 1;
    localparam int S_PC_LOAD  = 2;
    localparam int S_ADDR_EN  = 3;
    localparam int S_DATA_OUT = 4;
    localparam int S_LOAD     = 5;
    localparam int S_IR_IN    = 6;
    localparam int S_IR_OUT   = 7;
    localparam int S_A_IN     = 8;
    localparam int S_A_OUT    = 9;
    localparam int S_B_IN     = 10;
    localparam int S_ALU_OUT  = 11;
    localparam int S_SUB      = 12;
    localparam int S_OUT_IN   = 13;

    // One-hot strobe mask for a strobe index.
    function automatic logic [NSTB-1:0] stb(input int i);
        return NSTB'(1) << i;
    endfunction

endpackage

// File: rtl/control_seq_if.sv
// control_seq_if: bus/strobe bundle between the control sequencer and its environment.
//   master: drives program_mode and bus_in, observes IR operand, strobes, halted, step.
//   slave : the sequencer side (inputs program_mode/bus_in, drives everything else).
interface control_seq_if #(
    parameter int DW = 8
);
    logic          program_mode;
    logic [DW-1:0] bus_in;
    logic [DW-1:0] ir_bus;
    logic          pc_out;
    logic          pc_inc;
    logic          pc_load;
    logic          addr_en;
    logic          dataout_en;
    logic          load;
    logic          ir_in;
    logic          ir_out;
    logic          a_in;
    logic          a_out;
    logic          b_in;
    logic          alu_out;
    logic          sub;
    logic          out_in;
    logic          halted;
    logic [2:0]    step;

    modport master (
        output program_mode, bus_in,
        input  ir_bus, pc_out, pc_inc, pc_load, addr_en, dataout_en, load,
               ir_in, ir_out, a_in, a_out, b_in, alu_out, sub, out_in, halted, step
    );

    modport slave (
        input  program_mode, bus_in,
        output ir_bus, pc_out, pc_inc, pc_load, addr_en, dataout_en, load,
               ir_in, ir_out, a_in, a_out, b_in, alu_out, sub, out_in, halted, step
    );
endinterface

// File: rtl/control_seq_instr_reg.sv
// control_seq_instr_reg: DW-bit instruction register with load enable and async clear.
//   clk       in  system clock
//   clr       in  asynchronous active-high clear (IR <= 0)
//   i_ld      in  capture i_d on this posedge
//   i_d       in  instruction word from the shared bus
//   o_opcode  out IR[DW-1:DW-4]
//   o_operand out IR[3:0]
module control_seq_instr_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_ld,
    input  logic [DW-1:0] i_d,
    output logic [3:0]    o_opcode,
    output logic [3:0]    o_operand
);
    logic [DW-1:0] r_ir;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_ir <= '0;
        else if (i_ld) r_ir <= i_d;
    end

    assign o_opcode  = r_ir[DW-1:DW-4];
    assign o_operand = r_ir[3:0];
endmodule

// File: rtl/control_seq.sv
// control_seq: instruction register plus fixed-length microcode sequencer.
//   clk  in     system clock, all state on posedge
//   clr  in     asynchronous active-high reset (step 0, IR 0, not halted, strobes 0)
//   bus  slave  program_mode/bus_in in; ir_bus, control strobes, halted, step out
// Strobes are Moore outputs decoded from (step, IR) and gated to zero by clr,
// program_mode and the halt flag.
module control_seq
    import control_seq_pkg::*;
#(
    parameter int DW    = 8,
    parameter int STEPS = 5
) (
    input logic         clk,
    input logic         clr,
    control_seq_if.slave bus
);
    localparam logic [2:0] LAST = 3'(STEPS - 1);

    logic [2:0]      r_step;
    logic            r_halted;
    logic [3:0]      w_opcode;
    logic [3:0]      w_operand;
    logic            w_ir_ld;
    logic [NSTB-1:0] w_dec;
    logic [NSTB-1:0] w_stb;

    // IR is loaded on the edge leaving T1; program_mode parks the counter instead.
    assign w_ir_ld = (r_step == T1) && !bus.program_mode && !r_halted;

    control_seq_instr_reg #(.DW(DW)) u_ir (
        .clk      (clk),
        .clr      (clr),
        .i_ld     (w_ir_ld),
        .i_d      (bus.bus_in),
        .o_opcode (w_opcode),
        .o_operand(w_operand)
    );

    // HLT freezes the counter at T2; only clr releases it. program_mode returns to
    // T0 but keeps the halt flag.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_step   <= T0;
            r_halted <= 1'b0;
        end else if (bus.program_mode) begin
            r_step   <= T0;
        end else if (!r_halted) begin
            if (r_step == T2 && w_opcode == OP_HLT) r_halted <= 1'b1;
            else r_step <= (r_step == LAST) ? T0 : r_step + 3'd1;
        end
    end

    always_comb begin
        w_dec = '0;
        if (r_step == T0) w_dec = stb(S_PC_OUT) | stb(S_ADDR_EN);
        else if (r_step == T1) w_dec = stb(S_DATA_OUT) | stb(S_IR_IN) | stb(S_PC_INC);
        else begin
            case ({w_opcode, r_step})
                {OP_LDA, T2}, {OP_ADD, T2}, {OP_SUB, T2}, {OP_STA, T2}:
                              w_dec = stb(S_IR_OUT) | stb(S_ADDR_EN);
                {OP_LDA, T3}: w_dec = stb(S_DATA_OUT) | stb(S_A_IN);
                {OP_ADD, T3}: w_dec = stb(S_DATA_OUT) | stb(S_B_IN);
                {OP_SUB, T3}: w_dec = stb(S_DATA_OUT) | stb(S_B_IN) | stb(S_SUB);
                {OP_ADD, T4}: w_dec = stb(S_ALU_OUT) | stb(S_A_IN);
                {OP_SUB, T4}: w_dec = stb(S_ALU_OUT) | stb(S_A_IN) | stb(S_SUB);
                {OP_STA, T3}: w_dec = stb(S_A_OUT) | stb(S_LOAD);
                {OP_LDI, T2}: w_dec = stb(S_IR_OUT) | stb(S_A_IN);
                {OP_JMP, T2}: w_dec = stb(S_IR_OUT) | stb(S_PC_LOAD);
                {OP_OUT, T2}: w_dec = stb(S_A_OUT) | stb(S_OUT_IN);
                default:      w_dec = '0;
            endcase
        end
    end

    // clr gates combinationally so no strobe survives past the clr edge.
    assign w_stb = (clr || bus.program_mode || r_halted) ? '0 : w_dec;

    assign bus.pc_out     = w_stb[S_PC_OUT];
    assign bus.pc_inc     = w_stb[S_PC_INC];
    assign bus.pc_load    = w_stb[S_PC_LOAD];
    assign bus.addr_en    = w_stb[S_ADDR_EN];
    assign bus.dataout_en = w_stb[S_DATA_OUT];
    assign bus.load       = w_stb[S_LOAD];
    assign bus.ir_in      = w_stb[S_IR_IN];
    assign bus.ir_out     = w_stb[S_IR_OUT];
    assign bus.a_in       = w_stb[S_A_IN];
    assign bus.a_out      = w_stb[S_A_OUT];
    assign bus.b_in       = w_stb[S_B_IN];
    assign bus.alu_out    = w_stb[S_ALU_OUT];
    assign bus.sub        = w_stb[S_SUB];
    assign bus.out_in     = w_stb[S_OUT_IN];
    assign bus.ir_bus     = {{(DW-4){1'b0}}, w_operand};
    assign bus.halted     = r_halted;
    assign bus.step       = r_step;
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed table, hand sequences and random stimulus against a behavioural model.
module tb_control_seq;
    // Bench-local strobe bit order: {pc_out,pc_inc,pc_load,addr_en,dataout_en,load,ir_in,
    // ir_out,a_in,a_out,b_in,alu_out,sub,out_in}
    localparam logic [13:0] PO = 14'h2000, PI = 14'h1000, PL = 14'h0800, AE = 14'h0400,
                            DE = 14'h0200, LD = 14'h0100, II = 14'h0080, IO = 14'h0040,
                            AI = 14'h0020, AO = 14'h0010, BI = 14'h0008, AL = 14'h0004,
                            SU = 14'h0002, OI = 14'h0001;

    typedef struct {
        logic [7:0]  instr;
        int          st;
        logic [13:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    int         m_step;
    logic [7:0] m_ir;
    bit         m_halt;

    control_seq_if #(.DW(8)) cif ();
    control_seq #(.DW(8), .STEPS(5)) dut (.clk(clk), .clr(clr), .bus(cif));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [13:0] got_stb();
        return {cif.pc_out, cif.pc_inc, cif.pc_load, cif.addr_en, cif.dataout_en, cif.load,
                cif.ir_in, cif.ir_out, cif.a_in, cif.a_out, cif.b_in, cif.alu_out, cif.sub, cif.out_in};
    endfunction

    // Strobes the specification lists for an opcode in a given T-state.
    function automatic logic [13:0] spec_stb(input logic [3:0] op, input int st);
        if (st == 0) return PO | AE;
        if (st == 1) return DE | II | PI;
        case (op)
            4'h1: return st == 2 ? IO | AE : st == 3 ? DE | AI : 14'h0;
            4'h2: return st == 2 ? IO | AE : st == 3 ? DE | BI : st == 4 ? AL | AI : 14'h0;
            4'h3: return st == 2 ? IO | AE : st == 3 ? DE | BI | SU : st == 4 ? AL | AI | SU : 14'h0;
            4'h4: return st == 2 ? IO | AE : st == 3 ? AO | LD : 14'h0;
            4'h5: return st == 2 ? IO | AI : 14'h0;
            4'h6: return st == 2 ? IO | PL : 14'h0;
            4'hE: return st == 2 ? AO | OI : 14'h0;
            default: return 14'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model.
    task automatic tick(input logic pm, input logic [7:0] bin);
        int ndrv;
        @(negedge clk);
        cif.program_mode = pm;
        cif.bus_in = bin;
        #1;
        ndrv = int'(cif.pc_out) + int'(cif.dataout_en) + int'(cif.ir_out) + int'(cif.a_out) + int'(cif.alu_out);
        chk("strobes", int'(got_stb()), (pm || m_halt) ? 0 : int'(spec_stb(m_ir[7:4], m_step)));
        chk("step", int'(cif.step), m_step);
        chk("halted", int'(cif.halted), int'(m_halt));
        chk("ir_bus", int'(cif.ir_bus), int'(m_ir[3:0]));
        chk("one_driver", int'(ndrv <= 1), 1);
        @(posedge clk);
        if (pm) m_step = 0;
        else if (!m_halt) begin
            if (m_step == 1) m_ir = bin;
            if (m_step == 2 && m_ir[7:4] == 4'hF) m_halt = 1;
            else m_step = (m_step + 1) % 5;
        end
    endtask

    // Async clear held across one posedge; released just after it.
    task automatic do_clr();
        @(negedge clk);
        cif.program_mode = 1'b0;
        clr = 1'b1;
        #1;
        chk("clr_strobes", int'(got_stb()), 0);
        chk("clr_step", int'(cif.step), 0);
        chk("clr_ir", int'(cif.ir_bus), 0);
        @(posedge clk);
        #1;
        chk("clr_hold_step", int'(cif.step), 0);
        chk("clr_hold_halt", int'(cif.halted), 0);
        clr = 1'b0;
        m_step = 0;
        m_ir = 8'h00;
        m_halt = 0;
    endtask

    initial begin
        vec_t vt[$];
        logic [7:0] b;
        cif.program_mode = 1'b0;
        cif.bus_in = 8'h00;
        m_step = 0; m_ir = 8'h00; m_halt = 0;
        clr = 1'b1;
        #12;
        clr = 1'b0;

        vt.push_back('{8'h1A, 0, PO | AE});
        vt.push_back('{8'h1A, 1, DE | II | PI});
        vt.push_back('{8'h1A, 2, IO | AE});
        vt.push_back('{8'h1A, 3, DE | AI});
        vt.push_back('{8'h1A, 4, 14'h0});
        vt.push_back('{8'h3F, 3, DE | BI | SU});
        vt.push_back('{8'h3F, 4, AL | AI | SU});
        vt.push_back('{8'h25, 3, DE | BI});
        vt.push_back('{8'h25, 4, AL | AI});
        vt.push_back('{8'h47, 3, AO | LD});
        vt.push_back('{8'h57, 2, IO | AI});
        vt.push_back('{8'h63, 2, IO | PL});
        vt.push_back('{8'hE0, 2, AO | OI});
        vt.push_back('{8'h09, 2, 14'h0});
        vt.push_back('{8'h7C, 2, 14'h0});
        vt.push_back('{8'hD1, 3, 14'h0});

        foreach (vt[i]) begin
            do_clr();
            for (int k = 0; k < vt[i].st; k++) tick(1'b0, k == 1 ? vt[i].instr : 8'($urandom));
            @(negedge clk);
            #1;
            chk($sformatf("tbl%0d_stb", i), int'(got_stb()), int'(vt[i].exp));
            chk($sformatf("tbl%0d_step", i), int'(cif.step), vt[i].st);
            if (vt[i].st >= 2) chk($sformatf("tbl%0d_ir", i), int'(cif.ir_bus), int'(vt[i].instr[3:0]));
        end

        // HLT freezes at T2, survives program_mode, cleared only by clr
        do_clr();
        tick(1'b0, 8'h55);
        tick(1'b0, 8'hF0);
        tick(1'b0, 8'h11);
        for (int k = 0; k < 10; k++) tick(1'b0, 8'($urandom));
        @(negedge clk);
        #1;
        chk("hlt_step", int'(cif.step), 2);
        chk("hlt_flag", int'(cif.halted), 1);
        chk("hlt_strobes", int'(got_stb()), 0);
        tick(1'b1, 8'h00);
        tick(1'b1, 8'h00);
        for (int k = 0; k < 3; k++) tick(1'b0, 8'h12);
        chk("hlt_pm_flag", int'(cif.halted), 1);
        do_clr();
        tick(1'b0, 8'h00);

        // program_mode at T3 of LDA
        do_clr();
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h1A);
        tick(1'b0, 8'h00);
        tick(1'b1, 8'h00);
        @(negedge clk);
        #1;
        chk("pm_step", int'(cif.step), 0);
        chk("pm_ir", int'(cif.ir_bus), 8'h0A);
        for (int k = 0; k < 5; k++) tick(1'b0, 8'h2B);

        // clr mid-instruction (ADD at T3)
        do_clr();
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h2B);
        tick(1'b0, 8'h00);
        do_clr();
        tick(1'b0, 8'h00);

        // all opcodes through every T-state
        for (int op = 0; op < 16; op++) begin
            do_clr();
            tick(1'b0, 8'($urandom));
            tick(1'b0, {4'(op), 4'($urandom)});
            for (int k = 0; k < 3; k++) tick(1'b0, 8'($urandom));
        end

        // random traffic
        do_clr();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 40) == 0) do_clr();
            else begin
                b = 8'($urandom);
                if (b[7:4] == 4'hF && $urandom_range(0, 3) != 0) b[7:4] = 4'($urandom_range(0, 14));
                tick($urandom_range(0, 9) == 0, b);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
